fp_tloz_soc_pio_edge_in: RTL and testbench
==========================================

Name: fp_tloz_soc_pio_edge_in

Overview:
- Avalon-MM slave input PIO that samples external status or button lines into the SoC.
- Complement of the single-bit output PIO on the same bus:
  - external pins in, CPU reads out;
  - per-bit edge capture, interrupt mask and level IRQ to the Nios II.
- Sits on the system interconnect next to the output PIOs (USB reset, keycode and similar).

Parameters:
- WIDTH, 8, number of input lines (1..32).
- EDGE_TYPE, 0, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, synchronizer depth on in_port (2..4).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt to CPU.

Behaviour:
- Reset: all state clears asynchronously when reset_n=0.
  - Synchronizer flops, previous-sample register, edge_capture, irq_mask, readdata and irq are all 0.
  - Arm counter is 0.
- Synchronizer: in_port passes through SYNC_STAGES flops to give sync_in.
  - prev_in <= sync_in every cycle.
- Arm counter: counts up from 0 after reset release and saturates at SYNC_STAGES+1.
  - Edge detection is enabled only once the counter is saturated.
  - This suppresses spurious edges from inputs already high or low at reset release.
- Edge detect per bit i:
  - rising = sync_in[i] & ~prev_in[i]
  - falling = ~sync_in[i] & prev_in[i]
  - the selected event per EDGE_TYPE sets edge_capture[i], which is sticky.
- Register map:
  - 0 data: RO, read returns sync_in zero-extended. Writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: RW, WIDTH bits. Write loads writedata[WIDTH-1:0].
  - 3 edge_capture: R/W1C. A write clears each bit i where writedata[i]=1.
- Write condition: chipselect & ~write_n & address match. Takes effect on the next clk edge.
- Read: readdata is registered, giving read latency 1.
  - readdata <= mux(address), zero-extended, updated every cycle (no read strobe).
  - Upper 32-WIDTH bits are always 0.
- Simultaneous W1C clear and new edge on the same bit in the same cycle: set wins, bit stays 1.
  - Other bits clear normally.
- irq: registered, irq <= |(edge_capture & irq_mask).
  - Asserts 1 cycle after a capture bit and its mask bit are both 1.
  - Deasserts 1 cycle after the clear or unmask.
- Glitch narrower than one clk may be missed; that is not an error.
  - Any level held for ≥1 clk is seen.
- Reset mid-operation: all captured edges and the mask are lost; the arm sequence restarts.

Decomposition:
- Shared package holds:
  - register address constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- One natural sub-module, fp_tloz_sync_bus: WIDTH-wide, SYNC_STAGES-deep resettable synchronizer, reusable for other asynchronous inputs.
- Edge logic, registers and read mux stay in the top module.

Test Plan:
- Reset release with in_port=8'hFF held high, EDGE_TYPE=0 -> after 10 clks, read addr 3 returns 0 and irq=0. Read addr 0 returns 32'h000000FF with 1-cycle latency.
- Arm done; in_port 8'h00->8'h05 -> edge_capture=8'h05 SYNC_STAGES+1 clks later. irq stays 0 with mask 0. Write mask 8'h04 -> irq=1 one clk later.
- Write addr 3 writedata=32'h4 -> edge_capture=8'h01 and irq drops to 0 next clk. Write 32'hFFFFFFFF -> edge_capture=0.
- Schedule bit-2 rising edge to reach the detector in the same cycle as W1C of bit 2 -> edge_capture[2]=1 afterward.
- EDGE_TYPE=2, pulse in_port[7] high for 3 clks -> edge_capture[7]=1 (rising). Clear it -> the falling edge re-sets it to 1.
- Assert reset_n=0 mid-run with mask=8'hFF and capture=8'hFF -> readdata, irq, mask and capture all 0 immediately. No spurious capture after release with inputs static.

Source files
------------

// File: rtl/fp_tloz_soc_pio_edge_in_pkg.sv
// Shared definitions for the edge-capturing input PIO: register map and
// edge-type encodings used by the RTL and by software-facing benches.
package fp_tloz_soc_pio_edge_in_pkg;

    localparam int ADDR_W = 2;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/fp_tloz_soc_pio_edge_in_if.sv
// Avalon-MM slave bus of the input PIO, including its level interrupt line.
interface fp_tloz_soc_pio_edge_in_if;

    logic [fp_tloz_soc_pio_edge_in_pkg::ADDR_W-1:0] address;
    logic                                           chipselect;
    logic                                           write_n;
    logic [31:0]                                    writedata;
    logic [31:0]                                    readdata;
    logic                                           irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/fp_tloz_sync_bus.sv
// WIDTH-wide, STAGES-deep resettable synchronizer for asynchronous input lines.
module fp_tloz_sync_bus #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // NOTE: the synchronizer flops are reset as well, so the output is a known
    // 0 while the parent's arm window runs instead of X from metastable pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fp_tloz_soc_pio_edge_in.sv
// Input PIO: synchronized pins, sticky per-bit edge capture with W1C clear,
// interrupt mask and registered level IRQ; registered read data (latency 1).
module fp_tloz_soc_pio_edge_in
    import fp_tloz_soc_pio_edge_in_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    fp_tloz_soc_pio_edge_in_if.slave        bus,
    input  logic [WIDTH-1:0]                in_port
);

    localparam int                ARM_MAX  = SYNC_STAGES + 1;
    localparam int                ARM_W    = $clog2(ARM_MAX + 1);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(ARM_MAX);

    reg_addr_e         addr;
    logic [WIDTH-1:0]  sync_in;
    logic [WIDTH-1:0]  prev_in;
    logic [WIDTH-1:0]  edge_evt;
    logic [WIDTH-1:0]  cap_clr;
    logic [WIDTH-1:0]  edge_cap_d;
    logic [WIDTH-1:0]  edge_cap_q;
    logic [WIDTH-1:0]  irq_mask_q;
    logic [ARM_W-1:0]  arm_cnt_q;
    logic              armed;
    logic              wr_en;
    logic              wr_mask;
    logic              wr_cap;
    logic [31:0]       rd_mux;
    logic [31:0]       readdata_q;
    logic              irq_q;
    logic              unused_wdata;

    assign addr = reg_addr_e'(bus.address);

    fp_tloz_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_in)
    );

    // The arm counter keeps the first sync_in transition after reset release
    // (pins already high/low) from being mistaken for a real edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_in   <= '0;
            arm_cnt_q <= '0;
        end else begin
            prev_in <= sync_in;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + ARM_W'(1);
            end
        end
    end

    assign armed = (arm_cnt_q == ARM_DONE);

    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_evt = sync_in & ~prev_in;
            EDGE_FALLING: edge_evt = ~sync_in & prev_in;
            default:      edge_evt = sync_in ^ prev_in;
        endcase
    end

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wr_mask = wr_en & (addr == ADDR_IRQMASK);
    assign wr_cap  = wr_en & (addr == ADDR_EDGECAP);
    assign cap_clr = wr_cap ? bus.writedata[WIDTH-1:0] : '0;

    // Clear is applied before the set term, so a same-cycle edge wins.
    assign edge_cap_d = (edge_cap_q & ~cap_clr) | ({WIDTH{armed}} & edge_evt);

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap_q;
            default:      rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            edge_cap_q <= edge_cap_d;
            if (wr_mask) begin
                irq_mask_q <= bus.writedata[WIDTH-1:0];
            end
            readdata_q <= rd_mux;
            irq_q      <= |(edge_cap_q & irq_mask_q);
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

    // Bits above WIDTH are write-ignored by design.
    assign unused_wdata = &{1'b0, bus.writedata};

endmodule

// File: tb/tb_fp_tloz_soc_pio_edge_in.sv
// Bench for the input PIO: rising, falling and any-edge instances driven by
// one stimulus stream and compared every cycle against a history-based model.
module tb_fp_tloz_soc_pio_edge_in;

    localparam int S = 2;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] rd_w  [N];
    logic        irq_w [N];

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        fp_tloz_soc_pio_edge_in_if bus_if ();

        assign bus_if.address    = address;
        assign bus_if.chipselect = chipselect;
        assign bus_if.write_n    = write_n;
        assign bus_if.writedata  = writedata;

        fp_tloz_soc_pio_edge_in #(
            .WIDTH       (8),
            .EDGE_TYPE   (g),
            .SYNC_STAGES (S)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus_if),
            .in_port (in_port)
        );

        assign rd_w[g]  = bus_if.readdata;
        assign irq_w[g] = bus_if.irq;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: the pin value seen by the detector is simply the pin sampled S
    // clocks ago; the detector is live once S+1 clocks have passed since reset.
    logic [7:0]  m_cap  [N];
    logic [7:0]  m_mask;
    logic [31:0] m_rd   [N];
    logic        m_irq  [N];
    logic [7:0]  hist   [$];
    int          m_n;
    logic [7:0]  m_cur, m_prv, m_ev;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < N; t++) begin
                m_cap[t] = '0;
                m_rd[t]  = '0;
                m_irq[t] = 1'b0;
            end
            m_mask = '0;
            hist.delete();
            m_n = 0;
        end else begin
            m_cur = (m_n >= S)     ? hist[hist.size() - S]     : 8'h00;
            m_prv = (m_n >= S + 1) ? hist[hist.size() - S - 1] : 8'h00;
            for (int t = 0; t < N; t++) begin
                case (address)
                    2'd0:    m_rd[t] = {24'h0, m_cur};
                    2'd2:    m_rd[t] = {24'h0, m_mask};
                    2'd3:    m_rd[t] = {24'h0, m_cap[t]};
                    default: m_rd[t] = '0;
                endcase
                m_irq[t] = |(m_cap[t] & m_mask);
                if (t == 0)      m_ev = m_cur & ~m_prv;
                else if (t == 1) m_ev = ~m_cur & m_prv;
                else             m_ev = m_cur ^ m_prv;
                if (chipselect && !write_n && address == 2'd3) m_cap[t] = m_cap[t] & ~writedata[7:0];
                if (m_n >= S + 1) m_cap[t] = m_cap[t] | m_ev;
            end
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
            hist.push_back(in_port);
            if (hist.size() > S + 1) void'(hist.pop_front());
            if (m_n < 1000) m_n++;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int t = 0; t < N; t++) begin
                check($sformatf("cyc_rd_t%0d", t), rd_w[t], m_rd[t]);
                check($sformatf("cyc_irq_t%0d", t), {31'h0, irq_w[t]}, {31'h0, m_irq[t]});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();
    endtask

    initial begin
        reset_n    = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;
        tick();
        reset_n  = 1'b0;
        #1;
        model_on = 1'b1;
        ticks(2);
        reset_n = 1'b1;

        // Pins high through reset release: no capture, data reads back FF.
        ticks(10);
        read_reg(2'd3);
        for (int t = 0; t < N; t++) check($sformatf("rel_cap_t%0d", t), rd_w[t], 32'h0);
        check("rel_irq", {31'h0, irq_w[0]}, 32'h0);
        address = 2'd0;
        #1;
        check("rd_latency_old", rd_w[0], 32'h0);
        tick();
        for (int t = 0; t < N; t++) check($sformatf("rel_data_t%0d", t), rd_w[t], 32'h0000_00FF);

        // 00 -> 05 capture, then mask bit 2.
        in_port = 8'h00;
        ticks(4);
        in_port = 8'h05;
        ticks(S + 1);
        read_reg(2'd3);
        check("cap_05", rd_w[0], 32'h05);
        check("irq_unmasked", {31'h0, irq_w[0]}, 32'h0);
        wr(2'd2, 32'h4);
        check("irq_mask_lat", {31'h0, irq_w[0]}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq_w[0]}, 32'h1);

        // W1C of bit 2, then clear all.
        wr(2'd3, 32'h4);
        tick();
        check("irq_drop", {31'h0, irq_w[0]}, 32'h0);
        read_reg(2'd3);
        check("cap_after_w1c", rd_w[0], 32'h01);
        wr(2'd3, 32'hFFFF_FFFF);
        read_reg(2'd3);
        check("cap_clr_all", rd_w[0], 32'h0);

        // Bit-2 rise lands on the same edge as a W1C of bits 0 and 2.
        in_port = 8'h00;
        ticks(4);
        in_port = 8'h01;
        ticks(4);
        in_port = 8'h05;
        ticks(S);
        wr(2'd3, 32'h5);
        read_reg(2'd3);
        check("collide_set_wins", rd_w[0], 32'h04);
        wr(2'd3, 32'hFFFF_FFFF);

        // Bit-7 pulse of 3 clocks: any-edge re-captures on the falling edge.
        in_port = 8'h85;
        ticks(3);
        in_port = 8'h05;
        wr(2'd3, 32'h80);
        read_reg(2'd3);
        check("any_cleared", rd_w[2], 32'h0);
        check("rise_cleared", rd_w[0], 32'h0);
        ticks(2);
        check("any_fall_reset", rd_w[2], 32'h80);
        check("fall_capture", rd_w[1], 32'h80);
        check("rise_no_fall", rd_w[0], 32'h0);

        // Reset mid-run with everything set.
        wr(2'd2, 32'hFF);
        in_port = 8'h00;
        ticks(4);
        in_port = 8'hFF;
        ticks(4);
        read_reg(2'd3);
        check("pre_rst_cap", rd_w[0], 32'hFF);
        check("pre_rst_irq", {31'h0, irq_w[0]}, 32'h1);
        reset_n = 1'b0;
        #1;
        for (int t = 0; t < N; t++) begin
            check($sformatf("rst_rd_t%0d", t), rd_w[t], 32'h0);
            check($sformatf("rst_irq_t%0d", t), {31'h0, irq_w[t]}, 32'h0);
        end
        ticks(2);
        reset_n = 1'b1;
        ticks(10);
        read_reg(2'd2);
        check("post_rst_mask", rd_w[0], 32'h0);
        read_reg(2'd3);
        for (int t = 0; t < N; t++) check($sformatf("post_rst_cap_t%0d", t), rd_w[t], 32'h0);
        check("post_rst_irq", {31'h0, irq_w[0]}, 32'h0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) in_port = 8'($urandom);
            address    = 2'($urandom_range(3));
            chipselect = 1'($urandom_range(1));
            write_n    = ($urandom_range(3) != 0);
            writedata  = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(255));
            if ($urandom_range(299) == 0) begin
                reset_n = 1'b0;
                ticks(2);
                reset_n = 1'b1;
            end
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
